uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing one configurable-baud UART transmitter among
//  NUM_REQ requesters. Each requester offers a byte plus its own baud divisor;
//  the winner's byte and divisor are latched and launched with a one-cycle trmt.
//  The arbiter then waits for tx_done and reports completion to that requester.
//  Multi-byte packets hold the grant, guarded by an idle timeout.
// PARAMETERS
//  NUM_REQ   4     number of requesters (2..8)
//  LOCK_TO   1024  idle cycles before a held (packet) grant is dropped
// PORTS
//  clk        in   1            system clock, all logic posedge
//  rst        in   1            synchronous, active-high reset
//  req_vld    in   NUM_REQ      requester i has a byte pending
//  req_data   in   8*NUM_REQ    byte of requester i at [8i+7:8i]
//  req_baud   in   16*NUM_REQ   baud divisor of requester i at [16i+15:16i]
//  req_last   in   NUM_REQ      1 = final byte of packet (releases grant)
//  req_rdy    out  NUM_REQ      one-hot 1-cycle pulse: byte of requester i accepted
//  req_done   out  NUM_REQ      one-hot 1-cycle pulse: byte of requester i fully sent
//  trmt       out  1            1-cycle start strobe to transmitter
//  tx_data    out  8            latched byte to transmitter
//  baud       out  16           latched divisor, stable from trmt until tx_done
//  tx_done    in   1            transmitter done level (falls after trmt, rises at end)
//  grant      out  NUM_REQ      one-hot owner of the transmitter, 0 when unowned
//  busy       out  1            1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; req_rdy, req_done, trmt, grant, busy = 0; tx_data=0;
//   baud=0; rr_ptr=0; lock=0; lock_cnt=0. Reset mid-byte abandons it silently.
//  States: IDLE -> LAUNCH -> CLR -> WAIT -> IDLE.
//  IDLE: if lock=1, only the locked requester L may win. Otherwise the winner is
//   the first set req_vld scanning from rr_ptr upward, mod NUM_REQ.
//   On a win: req_rdy[w]=1 this cycle; latch req_data, req_baud, req_last of w;
//   grant=onehot(w); next LAUNCH. No vld (or locked L not vld): stay.
//  LAUNCH: trmt=1 for exactly this cycle; next CLR.
//  CLR: ignore tx_done (still stale high from the prior byte); next WAIT.
//  WAIT: when tx_done=1, req_done[g]=1 this cycle; next IDLE.
//   If latched last=1: lock<=0, grant<=0, rr_ptr<=(g+1)%NUM_REQ.
//   If latched last=0: lock<=1, L=g, lock_cnt<=0, grant held.
//  Lock timeout: in IDLE with lock=1 and req_vld[L]=0, lock_cnt increments.
//   At lock_cnt==LOCK_TO-1: lock<=0, grant<=0, rr_ptr<=(L+1)%NUM_REQ, next
//   cycle arbitrates normally. req_vld[L]=1 before that point resets lock_cnt.
//  Latency: accept (req_rdy) to trmt = 1 cycle; tx_done rise to req_done = 0 cycles.
//  Back-to-back: earliest next req_rdy is the cycle after req_done.
//  tx_data and baud change only on accept; held otherwise (incl. IDLE).
//  req_vld drop without req_rdy: request withdrawn, no side effects.
//  Simultaneous req_vld: exactly one req_rdy bit set; never more than one
//   grant, req_rdy or req_done bit set.
//  rr_ptr width = $clog2(NUM_REQ); wrap NUM_REQ-1 -> 0.
// TESTING
//  T1 single: req_vld=4'b0100, data=8'hA5, baud=16'd32, last=1 -> req_rdy[2] next
//     edge, trmt 1 cycle later, baud=32 held, req_done[2] on tx_done rise, grant=0.
//  T2 fairness: req_vld=4'b1111 held, all last=1 -> grant order 0,1,2,3,0,1.
//  T3 packet: req1 sends 3 bytes (last=0,0,1) while req0,req3 vld -> bytes of
//     req1 contiguous, then req3 (ptr=2), then req0.
//  T4 lock timeout: LOCK_TO=16, req2 sends last=0 then drops vld, req0 vld ->
//     req0 accepted exactly 16 idle cycles after req2 req_done; rr_ptr=3 before.
//  T5 reset mid-byte: assert rst in WAIT -> next cycle all outputs at reset
//     values, no req_done; first byte after reset starts arbitration at req0.
//  T6 stale tx_done: tx_done held 1 across CLR -> no premature req_done;
//     req_done fires only after tx_done is observed 0 then 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// The winner's byte and baud divisor are latched, launched with a trmt pulse, and completion is reported back.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LOCK_TO = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_vld,
    input  logic [8*NUM_REQ-1:0]  req_data,
    input  logic [16*NUM_REQ-1:0] req_baud,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_rdy,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  trmt,
    output logic [7:0]            tx_data,
    output logic [15:0]           baud,
    input  logic                  tx_done,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_TO + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TO - 1);

    // Handshake: req_rdy[i] is a single-cycle Mealy pulse in IDLE; the byte on
    // req_data/req_baud/req_last of requester i is taken at that clock edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        CLR    = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] lock_id;
    logic [PTR_W-1:0] grant_id;
    logic [PTR_W-1:0] win_id;
    logic [PTR_W-1:0] idx;
    logic             win_vld;
    logic             lock;
    logic             last_q;
    logic [CNT_W-1:0] lock_cnt;

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] p);
        if (int'(p) == NUM_REQ - 1) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        if (lock) begin
            win_vld = req_vld[lock_id];
            win_id  = lock_id;
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
                if (req_vld[idx]) begin
                    win_vld = 1'b1;
                    win_id  = idx;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        req_rdy    = '0;
        req_done   = '0;
        trmt       = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    req_rdy[win_id] = 1'b1;
                    state_next      = LAUNCH;
                end
            end
            LAUNCH: begin
                trmt       = 1'b1;
                state_next = CLR;
            end
            // tx_done may still be high from the previous byte here.
            CLR: state_next = WAIT;
            WAIT: begin
                if (tx_done) begin
                    req_done[grant_id] = 1'b1;
                    state_next         = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_id  <= '0;
            lock_cnt <= '0;
            grant    <= '0;
            grant_id <= '0;
            last_q   <= 1'b0;
            tx_data  <= '0;
            baud     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        tx_data  <= req_data[8*int'(win_id) +: 8];
                        baud     <= req_baud[16*int'(win_id) +: 16];
                        last_q   <= req_last[win_id];
                        grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                        grant_id <= win_id;
                        lock_cnt <= '0;
                    end else if (lock) begin
                        // Owner of an unfinished packet went quiet: drop the hold.
                        if (lock_cnt == CNT_MAX) begin
                            lock     <= 1'b0;
                            grant    <= '0;
                            rr_ptr   <= ptr_after(lock_id);
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        if (last_q) begin
                            lock   <= 1'b0;
                            grant  <= '0;
                            rr_ptr <= ptr_after(grant_id);
                        end else begin
                            lock     <= 1'b1;
                            lock_id  <= grant_id;
                            lock_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues feed the DUT, a transmitter model answers trmt,
// and a scoreboard checks every launch and completion against the expected byte order.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LOCK_TO = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_vld = '0;
    logic [8*NUM_REQ-1:0]  req_data = '0;
    logic [16*NUM_REQ-1:0] req_baud = '0;
    logic [NUM_REQ-1:0]    req_last = '0;
    logic [NUM_REQ-1:0]    req_rdy;
    logic [NUM_REQ-1:0]    req_done;
    logic                  trmt;
    logic [7:0]            tx_data;
    logic [15:0]           baud;
    logic                  tx_done = 1'b1;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_TO(LOCK_TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_baud (req_baud),
        .req_last (req_last),
        .req_rdy  (req_rdy),
        .req_done (req_done),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .baud     (baud),
        .tx_done  (tx_done),
        .grant    (grant),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / stimulus queues ----------------
    logic [26:0] exp_q[$];               // {id[2:0], data[7:0], baud[15:0]} in launch order
    logic [24:0] src_q[NUM_REQ][$];      // {last, baud[15:0], data[7:0]} per requester

    task automatic send(input int id, input logic [7:0] d, input logic [15:0] b, input logic last);
        src_q[id].push_back({last, b, d});
        exp_q.push_back({3'(id), d, b});
    endtask

    function automatic logic all_src_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [2:0] onehot_id(input logic [NUM_REQ-1:0] v);
        logic [2:0] r;
        r = 3'd7;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // ---------------- requester driver ----------------
    logic [NUM_REQ-1:0] drv_took;
    logic               drv_rst;

    always @(posedge clk) begin
        drv_took = req_rdy;
        drv_rst  = rst;
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!drv_rst && drv_took[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            if (src_q[i].size() != 0) begin
                req_vld[i]            = 1'b1;
                req_last[i]           = src_q[i][0][24];
                req_baud[16*i +: 16]  = src_q[i][0][23:8];
                req_data[8*i +: 8]    = src_q[i][0][7:0];
            end else begin
                req_vld[i] = 1'b0;
            end
        end
    end

    // ---------------- transmitter model ----------------
    int   byte_len   = 4;
    int   stale_hold = 0;
    int   tx_cnt     = 0;
    int   stale_cnt  = 0;
    logic tx_t;
    logic tx_r;

    always @(posedge clk) begin
        tx_t = trmt;
        tx_r = rst;
        #1;
        if (tx_r) begin
            tx_done   = 1'b1;
            tx_cnt    = 0;
            stale_cnt = 0;
        end else if (tx_t) begin
            tx_cnt    = byte_len;
            stale_cnt = stale_hold;
            if (stale_hold == 0) tx_done = 1'b0;
        end else if (stale_cnt > 0) begin
            stale_cnt--;
            if (stale_cnt == 0) tx_done = 1'b0;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    logic               inflight = 1'b0;
    logic               seen_low = 1'b0;
    logic [NUM_REQ-1:0] cur_grant = '0;
    logic [15:0]        cur_baud = '0;
    logic [7:0]         cur_data = '0;
    logic [26:0]        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            inflight = 1'b0;
            seen_low = 1'b0;
        end else begin
            if (req_rdy != '0) check_eq("rdy_onehot", $countones(req_rdy), 1);
            if (trmt) begin
                if (exp_q.size() == 0) begin
                    check_eq("trmt_unexpected", 32'(trmt), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("grant_onehot", $countones(grant), 1);
                    check_eq("launch_id", onehot_id(grant), mon_e[26:24]);
                    check_eq("launch_data", tx_data, mon_e[23:16]);
                    check_eq("launch_baud", baud, mon_e[15:0]);
                end
                cur_grant = grant;
                cur_baud  = baud;
                cur_data  = tx_data;
                inflight  = 1'b1;
                seen_low  = 1'b0;
            end else if (inflight && !tx_done) begin
                seen_low = 1'b1;
            end
            if (req_done != '0) begin
                check_eq("done_owner", req_done, cur_grant);
                check_eq("done_inflight", inflight, 1);
                check_eq("done_after_low", seen_low, 1);
                check_eq("hold_baud", baud, cur_baud);
                check_eq("hold_data", tx_data, cur_data);
                inflight = 1'b0;
            end
        end
    end

    // ---------------- helper tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_rdy(input int budget, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (req_rdy != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (req_done != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_drain(input int budget, input string tag);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (all_src_empty() && exp_q.size() == 0 && !busy && !inflight) ok = 1'b1;
        end
        check_eq(tag, ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic ok;
        int   ord[6];

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {req_rdy, req_done, grant, trmt, busy}, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_baud", baud, 0);
        rst = 1'b0;

        // T1: single byte from requester 2
        send(2, 8'hA5, 16'd32, 1'b1);
        wait_rdy(10, ok);
        check_eq("t1_rdy", req_rdy, 4'b0100);
        check_eq("t1_grant_pre", grant, 0);
        @(negedge clk);
        check_eq("t1_trmt", trmt, 1);
        check_eq("t1_grant", grant, 4'b0100);
        @(negedge clk);
        check_eq("t1_trmt_pulse", trmt, 0);
        check_eq("t1_baud", baud, 16'd32);
        check_eq("t1_data", tx_data, 8'hA5);
        wait_done(50, ok);
        check_eq("t1_done", req_done, 4'b0100);
        @(negedge clk);
        check_eq("t1_release", {grant, busy}, 0);
        check_eq("t1_data_held", tx_data, 8'hA5);
        wait_drain(20, "t1_drain");

        // T2: fairness with all requesters pending
        do_reset();
        ord = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) begin
            send(ord[i], 8'($urandom_range(0, 255)), 16'($urandom_range(1, 500)), 1'b1);
        end
        wait_drain(300, "t2_drain");

        // T3: multi-byte packet from requester 1 keeps the grant
        do_reset();
        send(0, 8'($urandom_range(0, 255)), 16'($urandom_range(1, 500)), 1'b1);
        wait_drain(50, "t3_pre");
        send(1, 8'h11, 16'($urandom_range(1, 500)), 1'b0);
        send(1, 8'h12, 16'($urandom_range(1, 500)), 1'b0);
        send(1, 8'h13, 16'($urandom_range(1, 500)), 1'b1);
        send(3, 8'h31, 16'($urandom_range(1, 500)), 1'b1);
        send(0, 8'h01, 16'($urandom_range(1, 500)), 1'b1);
        wait_drain(300, "t3_drain");

        // T4: lock timeout after an unfinished packet
        do_reset();
        send(2, 8'h22, 16'd100, 1'b0);
        wait_rdy(10, ok);
        send(0, 8'h02, 16'd200, 1'b1);
        wait_done(50, ok);
        check_eq("t4_done", req_done, 4'b0100);
        for (int k = 1; k <= LOCK_TO; k++) begin
            @(negedge clk);
            check_eq("t4_locked", {grant, req_rdy}, 8'b0100_0000);
        end
        @(negedge clk);
        check_eq("t4_rdy_timeout", req_rdy, 4'b0001);
        wait_drain(50, "t4_drain");

        // T5: reset while waiting for tx_done
        byte_len = 12;
        send(1, 8'h5A, 16'd77, 1'b1);
        wait_rdy(10, ok);
        check_eq("t5_rdy", req_rdy, 4'b0010);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("t5_in_wait", {busy, trmt, req_done}, 6'b100000);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_ctl", {req_rdy, req_done, grant, trmt, busy}, 0);
        check_eq("t5_rst_data", tx_data, 0);
        check_eq("t5_rst_baud", baud, 0);
        rst = 1'b0;
        byte_len = 4;
        send(0, 8'hC0, 16'd9, 1'b1);
        send(3, 8'hC3, 16'd10, 1'b1);
        wait_drain(100, "t5_drain");

        // T6: stale tx_done high across CLR
        stale_hold = 1;
        send(2, 8'h66, 16'd5, 1'b1);
        wait_rdy(10, ok);
        @(negedge clk);
        check_eq("t6_trmt", trmt, 1);
        @(negedge clk);
        check_eq("t6_clr", {tx_done, req_done}, 5'b10000);
        @(negedge clk);
        check_eq("t6_wait_low", {tx_done, req_done}, 0);
        wait_done(50, ok);
        check_eq("t6_done", req_done, 4'b0100);
        stale_hold = 0;
        wait_drain(20, "t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
